spm_mac_unit: RTL and testbench

- Parametrised successor to the team's 32x32 serial-parallel multiplier core.
- Multiplies a parallel multiplicand by a serially consumed multiplier, one multiplier bit per cycle.
- Adds signed (two's-complement) mode, optional accumulation into the previous result, and a busy flag.
- Sits behind the logic-analyzer bank: operands, start, select and result are all LA-driven, and the product is read one WIDTH-bit half at a time.

---
 rtl/spm_mac_unit_if.sv | 25 ++
 rtl/spm_mac_unit.sv | 98 +++++++++
 tb/tb_spm_mac_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_mac_unit_if.sv
// LA-side bus of the serial-parallel MAC: operands and controls in, status and selected
// product half out.
interface spm_mac_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic             start;
    logic             signed_mode;
    logic             acc_en;
    logic             prod_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod;

    modport master (
        output mc, mp, start, signed_mode, acc_en, prod_sel,
        input  busy, done, prod
    );

    modport slave (
        input  mc, mp, start, signed_mode, acc_en, prod_sel,
        output busy, done, prod
    );
endinterface

// File: rtl/spm_mac_unit.sv
// Serial-parallel multiply-accumulate: one multiplier bit per cycle into a 2*WIDTH-bit
// accumulator, with signed mode, optional accumulation and a busy/done handshake.
module spm_mac_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    spm_mac_unit_if.slave bus
);
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_accept;

    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mp;
    logic             r_signed;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;

    logic             w_last;
    logic             w_bit;
    logic [AW-1:0]    w_ext;
    logic [AW-1:0]    w_shift;
    logic [AW-1:0]    w_term;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Partial product for the current multiplier bit; the top bit carries negative
    // weight in signed mode, so its term is subtracted.
    always_comb begin
        w_last  = (r_cnt == CW'(WIDTH - 1));
        w_bit   = r_mp[r_cnt];
        w_ext   = {{WIDTH{r_signed & r_mc[WIDTH-1]}}, r_mc};
        w_shift = w_ext << r_cnt;
        w_term  = '0;
        if (w_bit) begin
            w_term = (r_signed && w_last) ? -w_shift : w_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_mc     <= '0;
            r_mp     <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mc     <= bus.mc;
                r_mp     <= bus.mp;
                r_signed <= bus.signed_mode;
                r_cnt    <= '0;
                if (!bus.acc_en) begin
                    r_acc <= '0;
                end
            end else if (r_state == StRun) begin
                r_acc <= r_acc + w_term;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        bus.busy = (r_state == StRun);
        bus.done = (r_state == StDone);
        bus.prod = bus.prod_sel ? r_acc[AW-1:WIDTH] : r_acc[WIDTH-1:0];
    end
endmodule

// File: tb/tb_spm_mac_unit.sv
// Bench for spm_mac_unit at WIDTH=32 and WIDTH=8 against a plain-arithmetic product model.
module tb_spm_mac_unit;
    localparam int W32 = 32;
    localparam int W8  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spm_mac_unit_if #(.WIDTH(W32)) b32 ();
    spm_mac_unit_if #(.WIDTH(W8))  b8 ();

    spm_mac_unit #(.WIDTH(W32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    spm_mac_unit #(.WIDTH(W8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_t = cycles since accept (-1 when idle); m_res is the result of the
    // operation in flight, m_acc the architecturally held accumulator.
    int           m_t   [2] = '{-1, -1};
    logic [127:0] m_acc [2] = '{128'd0, 128'd0};
    logic [127:0] m_res [2] = '{128'd0, 128'd0};

    function automatic int wof(input int d);
        return (d == 0) ? W32 : W8;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ext(input logic [63:0] x, input logic sm, input int w);
        logic [127:0] v;
        logic [127:0] wm;
        wm = (128'd1 << w) - 128'd1;
        v  = {64'd0, x} & wm;
        if (sm && v[w-1]) v = v | ~wm;
        return v;
    endfunction

    task automatic model_step(input int d, input logic s, input logic [63:0] mc,
                              input logic [63:0] mp, input logic sm, input logic ae);
        int           w;
        logic [127:0] mask;
        logic [127:0] p;
        w    = wof(d);
        mask = (128'd1 << (2 * w)) - 128'd1;
        if (rst) begin
            m_t[d]   = -1;
            m_acc[d] = '0;
        end else if (m_t[d] < 0) begin
            if (s) begin
                p        = (ext(mc, sm, w) * ext(mp, sm, w)) & mask;
                m_res[d] = ((ae ? m_acc[d] : 128'd0) + p) & mask;
                m_t[d]   = 0;
            end
        end else if (m_t[d] == w) begin
            m_t[d]   = -1;
            m_acc[d] = m_res[d];
        end else begin
            m_t[d]++;
        end
    endtask

    function automatic logic [63:0] exp_half(input int d, input logic sel);
        logic [127:0] v;
        logic [127:0] wm;
        int           w;
        w  = wof(d);
        wm = (128'd1 << w) - 128'd1;
        v  = (m_t[d] == w) ? m_res[d] : m_acc[d];
        v  = sel ? ((v >> w) & wm) : (v & wm);
        return v[63:0];
    endfunction

    task automatic compare_all();
        logic        busy, done, sel;
        logic [63:0] prod;
        int          w;
        for (int d = 0; d < 2; d++) begin
            w = wof(d);
            if (d == 0) begin
                busy = b32.busy; done = b32.done; sel = b32.prod_sel; prod = 64'(b32.prod);
            end else begin
                busy = b8.busy; done = b8.done; sel = b8.prod_sel; prod = 64'(b8.prod);
            end
            cmp($sformatf("w%0d busy", w), 64'(busy), 64'(m_t[d] >= 0 && m_t[d] < w));
            cmp($sformatf("w%0d done", w), 64'(done), 64'(m_t[d] == w));
            if (m_t[d] < 0 || m_t[d] == w)
                cmp($sformatf("w%0d prod sel%0d", w, sel), prod, exp_half(d, sel));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, b32.start, 64'(b32.mc), 64'(b32.mp), b32.signed_mode, b32.acc_en);
        model_step(1, b8.start, 64'(b8.mc), 64'(b8.mp), b8.signed_mode, b8.acc_en);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input int d, input logic [63:0] mc, input logic [63:0] mp,
                         input logic sm, input logic ae, input logic st);
        if (d == 0) begin
            b32.mc = mc[31:0]; b32.mp = mp[31:0];
            b32.signed_mode = sm; b32.acc_en = ae; b32.start = st;
        end else begin
            b8.mc = mc[7:0]; b8.mp = mp[7:0];
            b8.signed_mode = sm; b8.acc_en = ae; b8.start = st;
        end
    endtask

    task automatic rd(input int d, input logic sel, output logic [63:0] v);
        if (d == 0) begin
            b32.prod_sel = sel; #1; v = 64'(b32.prod);
        end else begin
            b8.prod_sel = sel; #1; v = 64'(b8.prod);
        end
    endtask

    function automatic logic dn(input int d);
        return (d == 0) ? b32.done : b8.done;
    endfunction

    // Cycles counted from the cycle start is presented through the done cycle, inclusive.
    task automatic do_op(input int d, input logic [63:0] mc, input logic [63:0] mp,
                         input logic sm, input logic ae);
        int cyc;
        int w;
        w = wof(d);
        drive(d, mc, mp, sm, ae, 1'b1);
        cyc = 1;
        tick();
        cyc++;
        drive(d, {$urandom, $urandom}, {$urandom, $urandom}, ~sm, ~ae, 1'b0);
        for (int i = 0; i < w + 10 && !dn(d); i++) begin
            tick();
            cyc++;
        end
        cmp($sformatf("w%0d start-to-done cycles", w), 64'(cyc), 64'(w + 2));
        tick();
    endtask

    task automatic chk_lit(input int d, input string name, input logic [63:0] lo,
                           input logic [63:0] hi);
        logic [63:0] v;
        rd(d, 1'b0, v);
        cmp({name, " lo"}, v, lo);
        rd(d, 1'b1, v);
        cmp({name, " hi"}, v, hi);
        cmp({name, " model lo"}, exp_half(d, 1'b0), lo);
        cmp({name, " model hi"}, exp_half(d, 1'b1), hi);
    endtask

    task automatic chk_model(input int d, input string name);
        logic [63:0] v;
        rd(d, 1'b0, v);
        cmp({name, " lo"}, v, exp_half(d, 1'b0));
        rd(d, 1'b1, v);
        cmp({name, " hi"}, v, exp_half(d, 1'b1));
    endtask

    initial begin
        int          t_done [$];
        int          bcnt;
        int          dcnt;
        logic [63:0] v;

        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        b32.prod_sel = 1'b0;
        b8.prod_sel  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_lit(0, "reset w32", 64'h0, 64'h0);
        chk_lit(1, "reset w8", 64'h0, 64'h0);

        // Unsigned and signed products.
        do_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0);
        chk_lit(0, "u max*max", 64'h0000_0001, 64'hFFFF_FFFE);
        do_op(0, 64'hFFFF_FFFD, 64'h0000_0005, 1'b1, 1'b0);
        chk_lit(0, "s -3*5", 64'hFFFF_FFF1, 64'hFFFF_FFFF);
        do_op(0, 64'h0000_0005, 64'hFFFF_FFFD, 1'b1, 1'b0);
        chk_lit(0, "s 5*-3", 64'hFFFF_FFF1, 64'hFFFF_FFFF);
        do_op(0, 64'h8000_0000, 64'h8000_0000, 1'b1, 1'b0);
        chk_lit(0, "s min*min", 64'h0000_0000, 64'h4000_0000);

        // Accumulation, including silent wrap.
        do_op(0, 7, 6, 1'b0, 1'b0);
        do_op(0, 10, 10, 1'b0, 1'b1);
        chk_lit(0, "acc 42+100", 64'h0000_008E, 64'h0);
        do_op(0, 64'hFFFF_FFFF, 64'h1, 1'b1, 1'b0);
        chk_lit(0, "preload -1", 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        do_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b1);
        chk_lit(0, "acc wrap", 64'h0000_0000, 64'hFFFF_FFFE);

        // Start held high: one op per WIDTH+2 cycles, operands changed mid-run.
        drive(0, 3, 4, 1'b0, 1'b0, 1'b1);
        b32.prod_sel = 1'b0;
        bcnt = 0;
        for (int t = 1; t <= 3 * (W32 + 2); t++) begin
            tick();
            if (b32.busy) bcnt++;
            if (b32.done) begin
                t_done.push_back(t);
                if (t_done.size() == 1) begin
                    rd(0, 1'b0, v);
                    cmp("held-start first result", v, 64'd12);
                end
            end
            if (t == 10) begin
                b32.mc = $urandom;
                b32.mp = $urandom;
            end
        end
        b32.start = 1'b0;
        cmp("held-start done count", 64'(t_done.size()), 64'd3);
        cmp("held-start busy cycles", 64'(bcnt), 64'(3 * W32));
        if (t_done.size() == 3) begin
            cmp("held-start period 1", 64'(t_done[1] - t_done[0]), 64'(W32 + 2));
            cmp("held-start period 2", 64'(t_done[2] - t_done[1]), 64'(W32 + 2));
        end
        for (int i = 0; i < W32 + 4; i++) tick();

        // Reset mid-operation at cnt=10.
        drive(0, 100, 200, 1'b0, 1'b0, 1'b1);
        tick();
        b32.start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("abort busy", 64'(b32.busy), 64'd0);
        cmp("abort done", 64'(b32.done), 64'd0);
        chk_lit(0, "abort prod", 64'h0, 64'h0);
        dcnt = 0;
        for (int i = 0; i < W32 + 8; i++) begin
            tick();
            if (b32.done) dcnt++;
        end
        cmp("abort no done", 64'(dcnt), 64'd0);
        do_op(0, 3, 4, 1'b0, 1'b0);
        chk_lit(0, "after abort 3*4", 64'd12, 64'd0);

        // WIDTH=8 sweep.
        do_op(1, 64'h80, 64'h80, 1'b1, 1'b0);
        chk_lit(1, "w8 s min*min", 64'h00, 64'h40);
        do_op(1, 64'hFF, 64'hFF, 1'b0, 1'b0);
        chk_lit(1, "w8 u max*max", 64'h01, 64'hFE);
        for (int i = 0; i < 40; i++) begin
            do_op(1, 64'($urandom_range(255)), 64'($urandom_range(255)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            chk_model(1, $sformatf("w8 rand %0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            do_op(0, 64'($urandom), 64'($urandom), 1'($urandom_range(1)),
                  1'($urandom_range(1)));
            chk_model(0, $sformatf("w32 rand %0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
